id_ex_fwd_reg: RTL and testbench

ID/EX pipeline register that feeds the EX-stage operand selectors.
- Captures decoded operands and control from ID.
- Precomputes and registers the 2-bit forwarding selects for the two 3-input EX operand muxes: 00 = register-file data, 01 = EX/MEM result, 10 = MEM/WB result.
- Detects load-use hazards, inserts a one-cycle bubble, and handles pipeline hold and flush.

---
 rtl/id_ex_fwd_reg_pkg.sv | 18 +
 rtl/id_ex_fwd_reg_fwd_sel_gen.sv | 37 +++
 rtl/id_ex_fwd_reg.sv | 120 ++++++++++++
 tb/tb_id_ex_fwd_reg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared CPU definitions for the ID/EX boundary: operand-forwarding select
// encodings, register specifier width and the registered EX control bundle.
package id_ex_fwd_reg_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                          valid;
    logic                          reg_write;
    logic                          mem_read;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
  } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_fwd_reg_fwd_sel_gen.sv
// Forwarding select for one EX operand, evaluated from the ID-stage source
// against the producers that will sit in MEM and WB next cycle.
module fwd_sel_gen
  import id_ex_fwd_reg_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_WIDTH-1:0] i_rs,
  input  logic                      i_ex_valid,
  input  logic                      i_ex_reg_write,
  input  logic                      i_ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  input  logic                      i_mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  output logic [1:0]                o_sel
);

  logic w_rs_nz;
  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX cannot forward from EX/MEM; that case is the load-use bubble.
  assign w_rs_nz   = (i_rs != '0);
  assign w_ex_hit  = i_ex_valid & i_ex_reg_write & ~i_ex_mem_read &
                     (i_ex_rd == i_rs) & w_rs_nz;
  assign w_mem_hit = i_mem_reg_write & (i_mem_rd == i_rs) & w_rs_nz;

  always_comb begin
    o_sel = FWD_REG;
    if (w_ex_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with registered forwarding selects, load-use
// bubble insertion, downstream hold and branch flush.
module id_ex_fwd_reg
  import id_ex_fwd_reg_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  output logic                      hazard_stall,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel
);

  id_ex_ctrl_t           r_ctrl;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_rs1_data;
  logic [DATA_WIDTH-1:0] r_rs2_data;
  logic [DATA_WIDTH-1:0] r_imm;
  logic [1:0]            r_fwd_a;
  logic [1:0]            r_fwd_b;

  logic [1:0]            w_sel_a;
  logic [1:0]            w_sel_b;
  logic                  w_load_use;

  fwd_sel_gen #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_sel_a (
    .i_rs            (id_rs1),
    .i_ex_valid      (r_ctrl.valid),
    .i_ex_reg_write  (r_ctrl.reg_write),
    .i_ex_mem_read   (r_ctrl.mem_read),
    .i_ex_rd         (r_ctrl.rd),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd        (mem_rd),
    .o_sel           (w_sel_a)
  );

  fwd_sel_gen #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_sel_b (
    .i_rs            (id_rs2),
    .i_ex_valid      (r_ctrl.valid),
    .i_ex_reg_write  (r_ctrl.reg_write),
    .i_ex_mem_read   (r_ctrl.mem_read),
    .i_ex_rd         (r_ctrl.rd),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd        (mem_rd),
    .o_sel           (w_sel_b)
  );

  // Handshake: ID advances only when hazard_stall=0 and stall_in=0; stall_in
  // freezes this stage; hazard_stall holds ID while EX takes a bubble.
  assign w_load_use   = id_valid & r_ctrl.valid & r_ctrl.mem_read &
                        (r_ctrl.rd != '0) &
                        ((r_ctrl.rd == id_rs1) | (r_ctrl.rd == id_rs2));
  assign hazard_stall = w_load_use & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_fwd_a    <= FWD_REG;
      r_fwd_b    <= FWD_REG;
    end else if (flush || (!stall_in && w_load_use)) begin
      // Bubble: only control is cleared, data fields keep stale values.
      r_ctrl.valid     <= 1'b0;
      r_ctrl.reg_write <= 1'b0;
      r_ctrl.mem_read  <= 1'b0;
      r_fwd_a          <= FWD_REG;
      r_fwd_b          <= FWD_REG;
    end else if (!stall_in) begin
      r_ctrl.valid     <= id_valid;
      r_ctrl.reg_write <= id_reg_write & id_valid;
      r_ctrl.mem_read  <= id_mem_read & id_valid;
      r_ctrl.rd        <= id_rd;
      r_pc             <= id_pc;
      r_rs1_data       <= id_rs1_data;
      r_rs2_data       <= id_rs2_data;
      r_imm            <= id_imm;
      r_fwd_a          <= w_sel_a;
      r_fwd_b          <= w_sel_b;
    end
  end

  assign ex_valid     = r_ctrl.valid;
  assign ex_reg_write = r_ctrl.reg_write;
  assign ex_mem_read  = r_ctrl.mem_read;
  assign ex_rd        = r_ctrl.rd;
  assign ex_pc        = r_pc;
  assign ex_rs1_data  = r_rs1_data;
  assign ex_rs2_data  = r_rs2_data;
  assign ex_imm       = r_imm;
  assign fwd_a_sel    = r_fwd_a;
  assign fwd_b_sel    = r_fwd_b;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg: the driver pushes hand-computed
// expectations per cycle, a monitor pops and compares them against the DUT.
module tb_id_ex_fwd_reg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int W  = 48;

  logic          clk;
  logic          rst;
  logic          stall_in;
  logic          flush;
  logic          id_valid;
  logic [DW-1:0] id_pc;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] id_rd;
  logic [DW-1:0] id_rs1_data;
  logic [DW-1:0] id_rs2_data;
  logic [DW-1:0] id_imm;
  logic          id_reg_write;
  logic          id_mem_read;
  logic [AW-1:0] mem_rd;
  logic          mem_reg_write;
  logic          hazard_stall;
  logic          ex_valid;
  logic [DW-1:0] ex_pc;
  logic [DW-1:0] ex_rs1_data;
  logic [DW-1:0] ex_rs2_data;
  logic [DW-1:0] ex_imm;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic [1:0]    fwd_a_sel;
  logic [1:0]    fwd_b_sel;

  // Item: [47]hz_chk [46]hz [45]reg_chk [44]valid [43]reg_write [42]mem_read
  //       [41:40]fwd_a [39:38]fwd_b [37]data_chk [36:32]rd [31:0]pc
  logic [W-1:0] exp_q[$];
  int           n_tests;
  int           n_fail;

  id_ex_fwd_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rd         (id_rd),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_imm        (id_imm),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .hazard_stall  (hazard_stall),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_rs1_data   (ex_rs1_data),
    .ex_rs2_data   (ex_rs2_data),
    .ex_imm        (ex_imm),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [DW-1:0] pc,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic rw, input logic mr);
    id_valid     = v;
    id_pc        = pc;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_rs1_data  = pc * 3;
    id_rs2_data  = pc * 5;
    id_imm       = pc << 1;
  endtask

  task automatic set_mem(input logic [AW-1:0] rd, input logic rw);
    mem_rd        = rd;
    mem_reg_write = rw;
  endtask

  task automatic push(input logic hchk, input logic hz, input logic rchk,
                      input logic v, input logic rw, input logic mr,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic pchk, input logic [AW-1:0] rd,
                      input logic [DW-1:0] pc);
    exp_q.push_back({hchk, hz, rchk, v, rw, mr, fa, fb, pchk, rd, pc});
  endtask

  // Scoreboard
  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e[47]) chk("hazard_stall", DW'(hazard_stall), DW'(e[46]));
        @(posedge clk);
        #1;
        if (e[45]) begin
          chk("ex_valid", DW'(ex_valid), DW'(e[44]));
          chk("ex_reg_write", DW'(ex_reg_write), DW'(e[43]));
          chk("ex_mem_read", DW'(ex_mem_read), DW'(e[42]));
          chk("fwd_a_sel", DW'(fwd_a_sel), DW'(e[41:40]));
          chk("fwd_b_sel", DW'(fwd_b_sel), DW'(e[39:38]));
        end
        if (e[37]) begin
          chk("ex_rd", DW'(ex_rd), DW'(e[36:32]));
          chk("ex_pc", ex_pc, e[31:0]);
          chk("ex_rs1_data", ex_rs1_data, e[31:0] * 3);
          chk("ex_rs2_data", ex_rs2_data, e[31:0] * 5);
          chk("ex_imm", ex_imm, e[31:0] << 1);
        end
      end
    end
  end

  // Stimulus
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    stall_in = 1'b0;
    flush    = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    set_mem('0, 1'b0);

    // reset held two cycles with a valid ID instruction
    nxt(); set_id(1, 'h10, 1, 2, 3, 1, 0);
    push(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    nxt(); push(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);

    // EX forwarding and x0
    nxt(); rst = 1'b0; set_id(1, 'h20, 1, 2, 5, 1, 0);
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 5, 'h20);
    nxt(); set_id(1, 'h24, 5, 6, 8, 1, 0);
    push(1, 0, 1, 1, 1, 0, 1, 0, 1, 8, 'h24);
    nxt(); set_id(1, 'h28, 0, 0, 0, 1, 0);
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 0, 'h28);
    nxt(); set_id(1, 'h2c, 0, 0, 7, 1, 0); set_mem(0, 1);
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 7, 'h2c);

    // MEM forwarding and EX priority
    nxt(); set_id(1, 'h30, 1, 7, 9, 0, 0); set_mem(7, 1);
    push(1, 0, 1, 1, 0, 0, 0, 1, 1, 9, 'h30);
    nxt(); set_id(1, 'h34, 1, 7, 10, 1, 0);
    push(1, 0, 1, 1, 1, 0, 0, 2, 1, 10, 'h34);

    // load-use bubble then MEM/WB forward
    nxt(); set_id(1, 'h38, 2, 4, 3, 1, 1); set_mem(0, 0);
    push(1, 0, 1, 1, 1, 1, 0, 0, 1, 3, 'h38);
    nxt(); set_id(1, 'h3c, 3, 6, 11, 1, 0);
    push(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); set_mem(3, 1);
    push(1, 0, 1, 1, 1, 0, 2, 0, 1, 11, 'h3c);

    // flush beats load-use
    nxt(); set_id(1, 'h40, 1, 2, 12, 1, 1); set_mem(0, 0);
    push(1, 0, 1, 1, 1, 1, 0, 0, 1, 12, 'h40);
    nxt(); set_id(1, 'h44, 5, 12, 13, 1, 0); flush = 1'b1;
    push(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); flush = 1'b0; set_id(1, 'h48, 12, 0, 14, 1, 0);
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 14, 'h48);

    // stall_in with load-use: hold, hazard stays up, then one bubble
    nxt(); set_id(1, 'h4c, 1, 2, 15, 1, 1);
    push(1, 0, 1, 1, 1, 1, 0, 0, 1, 15, 'h4c);
    nxt(); set_id(1, 'h50, 15, 0, 16, 1, 0); stall_in = 1'b1;
    push(1, 1, 1, 1, 1, 1, 0, 0, 1, 15, 'h4c);
    nxt(); push(1, 1, 1, 1, 1, 1, 0, 0, 1, 15, 'h4c);
    nxt(); stall_in = 1'b0;
    push(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt(); set_mem(15, 1);
    push(1, 0, 1, 1, 1, 0, 2, 0, 1, 16, 'h50);

    // stall_in holds ex_pc
    nxt(); set_mem(0, 0); set_id(1, 'h100, 1, 2, 17, 1, 0);
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 17, 'h100);
    for (int i = 0; i < 3; i++) begin
      nxt(); set_id(1, 'h104, 1, 2, 18, 1, 0); stall_in = 1'b1;
      push(1, 0, 1, 1, 1, 0, 0, 0, 1, 17, 'h100);
    end
    nxt(); stall_in = 1'b0;
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 18, 'h104);

    // invalid ID: control masked, selects still computed
    nxt(); set_id(0, 'h108, 18, 0, 19, 1, 1);
    push(1, 0, 1, 0, 0, 0, 1, 0, 1, 19, 'h108);

    // reset during a stalled load-use
    nxt(); set_id(1, 'h10c, 1, 2, 20, 1, 1);
    push(1, 0, 1, 1, 1, 1, 0, 0, 1, 20, 'h10c);
    nxt(); set_id(1, 'h110, 20, 2, 21, 1, 0); stall_in = 1'b1;
    push(1, 1, 1, 1, 1, 1, 0, 0, 1, 20, 'h10c);
    nxt(); rst = 1'b1;
    push(1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    nxt(); rst = 1'b0; stall_in = 1'b0;
    push(1, 0, 1, 1, 1, 0, 0, 0, 1, 21, 'h110);

    nxt();
    nxt();
    chk("scoreboard_drained", DW'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
